// File: rtl/stream_mux_rr_if.sv
// Stream bus for stream_mux_rr: NUM_CH input valid/ready channels merged onto one output.
// in_last/out_last exist only when STREAM_MUX_LOCK_EN is defined.
interface stream_mux_rr_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH_W-1:0]         out_ch;
`ifdef STREAM_MUX_LOCK_EN
  logic [NUM_CH-1:0]       in_last;
  logic                    out_last;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_ch, out_last
  );
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_ch, out_last
  );
`else
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// Round-robin N:1 valid/ready stream merge with a registered output stage.
// Optional atomic-burst locking is enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
) (
  input logic            clk,
  input logic            rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [WIDTH-1:0]  data_q;
  logic              valid_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   last_grant;

  logic              load;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              any_grant;
  logic [WIDTH-1:0]  sel_data;

  assign load = ~valid_q | bus.out_ready;

`ifdef STREAM_MUX_LOCK_EN
  logic lock;
  logic last_q;
  logic sel_last;

  // While locked, last_grant holds the burst owner and only it may compete.
  assign eligible = lock ? (bus.in_valid & (NUM_CH'(1) << last_grant)) : bus.in_valid;

  always_comb begin
    sel_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel_last = bus.in_last[i];
    end
  end

  assign bus.out_last = last_q;
`else
  assign eligible = bus.in_valid;
`endif

  always_comb begin : arb
    logic [CH_W-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!any_grant && eligible[idx]) begin
        any_grant      = 1'b1;
        grant_idx      = idx;
        grant[idx]     = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign bus.in_ready  = load ? grant : '0;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_ch    = ch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      ch_q       <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
`ifdef STREAM_MUX_LOCK_EN
      lock       <= 1'b0;
      last_q     <= 1'b0;
`endif
    end else if (load) begin
      if (any_grant) begin
        data_q     <= sel_data;
        valid_q    <= 1'b1;
        ch_q       <= grant_idx;
        last_grant <= grant_idx;
`ifdef STREAM_MUX_LOCK_EN
        lock       <= ~sel_last;
        last_q     <= sel_last;
`endif
      end else begin
        valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: spec-level scoreboard plus directed literal checks.
module tb_stream_mux_rr;
  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  stream_mux_rr_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

  stream_mux_rr #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NUM_CH-1:0] v, input int last);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (v[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic set_data(input int ch, input logic [WIDTH-1:0] d);
    bus.in_data[ch*WIDTH +: WIDTH] = d;
  endtask

  // Reference model: output register contents and arbitration pointer.
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_lg;
  logic             m_lock;
  logic             m_last;

  always @(negedge clk) begin : scoreboard
    int                w;
    logic              ld;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] exp_rdy;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_lg    = NUM_CH - 1;
      m_lock  = 1'b0;
      m_last  = 1'b0;
    end
    ld   = !m_valid || bus.out_ready;
    elig = bus.in_valid;
    if (m_lock) elig = bus.in_valid & (NUM_CH'(1) << m_lg);
    w       = pick(elig, m_lg);
    exp_rdy = (ld && w >= 0) ? (NUM_CH'(1) << w) : '0;

    check("sb_out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("sb_out_data",  32'(bus.out_data),  32'(m_data));
    check("sb_out_ch",    32'(bus.out_ch),    32'(m_ch));
    check("sb_in_ready",  32'(bus.in_ready),  32'(exp_rdy));
`ifdef STREAM_MUX_LOCK_EN
    check("sb_out_last",  32'(bus.out_last),  32'(m_last));
`endif

    if (rst_n && ld) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = bus.in_data[w*WIDTH +: WIDTH];
        m_ch    = w;
        m_lg    = w;
`ifdef STREAM_MUX_LOCK_EN
        m_last  = bus.in_last[w];
        m_lock  = !bus.in_last[w];
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [WIDTH-1:0] seq_d [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
  int               seq_c [5] = '{0, 1, 2, 3, 0};
`ifdef STREAM_MUX_LOCK_EN
  int               burst_c [5] = '{1, 1, 1, 2, 0};
  logic             burst_l [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
  int               burst_c [5] = '{1, 2, 0, 1, 2};
`endif

  initial begin
    int   k;
    logic acc;
    errors = 0;
    checks = 0;
    rst_n         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last   = '0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_ch",    32'(bus.out_ch),    32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);

    // Full-rate rotation over all channels.
    set_data(0, 8'h10); set_data(1, 8'h21); set_data(2, 8'h32); set_data(3, 8'h43);
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last = '1;
`endif
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("rot_data",  32'(bus.out_data),  32'(seq_d[i]));
      check("rot_ch",    32'(bus.out_ch),    32'(seq_c[i]));
      check("rot_valid", 32'(bus.out_valid), 32'd1);
    end

    // Nothing valid: out_valid drops, data and tag hold.
    bus.in_valid = 4'b0000;
    @(posedge clk); #2;
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    check("idle_data",  32'(bus.out_data),  32'h10);
    check("idle_ch",    32'(bus.out_ch),    32'd0);

    // Capture one word into an empty register, then stall.
    set_data(2, 8'hA5);
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b0;
    @(posedge clk); #2;
    check("cap_data",  32'(bus.out_data),  32'hA5);
    check("cap_valid", 32'(bus.out_valid), 32'd1);
    check("cap_ch",    32'(bus.out_ch),    32'd2);
    check("cap_ready", 32'(bus.in_ready),  32'd0);
    repeat (5) begin
      @(posedge clk); #2;
      check("stall_data",  32'(bus.out_data), 32'hA5);
      check("stall_ready", 32'(bus.in_ready), 32'd0);
    end
    set_data(2, 8'h5A);
    bus.out_ready = 1'b1;
    @(posedge clk); #2;
    check("drain_data", 32'(bus.out_data), 32'h5A);
    check("drain_ch",   32'(bus.out_ch),   32'd2);

    // Wrap-around from last_grant=3.
    set_data(3, 8'hC3); set_data(0, 8'hC0);
    bus.in_valid = 4'b1000;
    @(posedge clk); #2;
    check("wrap_pre_ch", 32'(bus.out_ch), 32'd3);
    bus.in_valid = 4'b1001;
    @(posedge clk); #2;
    check("wrap_ch0",   32'(bus.out_ch),   32'd0);
    check("wrap_data0", 32'(bus.out_data), 32'hC0);
    @(posedge clk); #2;
    check("wrap_ch3",   32'(bus.out_ch),   32'd3);
    check("wrap_data3", 32'(bus.out_data), 32'hC3);

    // Asynchronous reset between edges.
    set_data(0, 8'h10); set_data(1, 8'h21); set_data(2, 8'h32); set_data(3, 8'h43);
    bus.in_valid = 4'b1111;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data",  32'(bus.out_data),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("post_rst_ch",   32'(bus.out_ch),   32'd0);
    check("post_rst_data", 32'(bus.out_data), 32'h10);

    // ch1 three-word burst competing with ch0 and ch2.
    k = 0;
    set_data(0, 8'hD0); set_data(2, 8'hD2); set_data(1, 8'hB1);
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last = 4'b1101;
`endif
    bus.in_valid = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc = bus.in_ready[1] & bus.in_valid[1];
      @(posedge clk); #2;
      if (acc) begin
        k++;
        if (k == 3) bus.in_valid[1] = 1'b0;
        else set_data(1, 8'hB1 + 8'(k));
`ifdef STREAM_MUX_LOCK_EN
        bus.in_last[1] = (k == 2);
`endif
      end
      check("burst_ch", 32'(bus.out_ch), 32'(burst_c[i]));
`ifdef STREAM_MUX_LOCK_EN
      check("burst_last", 32'(bus.out_last), 32'(burst_l[i]));
`endif
    end

    // Burst owner goes idle mid-burst; ch0 stays valid.
    set_data(1, 8'hE1);
`ifdef STREAM_MUX_LOCK_EN
    bus.in_last = 4'b0001;
`endif
    bus.in_valid = 4'b0011;
    @(posedge clk); #2;
    bus.in_valid = 4'b0001;
    @(posedge clk); #2;
`ifdef STREAM_MUX_LOCK_EN
    check("lock_idle_ready", 32'(bus.in_ready),  32'd0);
    check("lock_idle_valid", 32'(bus.out_valid), 32'd0);
`else
    check("nolock_ch0", 32'(bus.out_ch), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel successor to the team's 2:1 byte selector.
- Merges NUM_CH valid/ready input streams of WIDTH bits onto one registered output stream, using fair round-robin arbitration.
- Sits between the per-channel key/plaintext sources and the XOR cipher core, replacing hard-wired select lines with a flow-controlled merge.

Parameters:
- WIDTH, 8, data width of every channel and of the output.
- NUM_CH, 4, number of input channels; legal range 2..16.
- CH_W, derived localparam = $clog2(NUM_CH), width of the channel tag; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel data-valid.
- in_ready  output  NUM_CH  per-channel accept; one-hot or zero.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream accept.
- out_ch  output  CH_W  index of the channel that sourced out_data.
- in_last  input  NUM_CH  end-of-burst marker per channel; present only with STREAM_MUX_LOCK_EN.
- out_last  output  1  registered copy of the winner's in_last; present only with STREAM_MUX_LOCK_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ch=0, out_last=0, last_grant=NUM_CH-1, lock=0. After reset, channel 0 has the highest priority.
- load = ~out_valid | out_ready. The output register accepts a new word whenever it is empty or is being drained in the same cycle.
- Arbitration is combinational from in_valid and last_grant. Search order is last_grant+1, +2, … modulo NUM_CH; the first asserted in_valid wins.
- in_ready[i] = load & grant[i]. Never assert in_ready on a channel with in_valid=0. At most one in_ready bit is high.
- A transfer on channel i occurs when in_valid[i] & in_ready[i]. On the next edge:
  - out_data <= channel i data
  - out_ch <= i
  - out_valid <= 1
  - last_grant <= i
- If load=1 and no channel is valid, out_valid <= 0. out_data and out_ch hold their previous values.
- If load=0 (out_valid=1 & out_ready=0), all output registers and last_grant hold and every in_ready is 0. The output does not change while stalled.
- Latency: one cycle from input acceptance to out_valid.
- Throughput: one word per cycle when out_ready stays high. A full-rate downstream sees no bubbles.
- Fairness: with all channels continuously valid, grants rotate 0,1,…,NUM_CH-1,0,… with no channel served twice before every other valid channel is served once.
- Simultaneous drain and refill: when out_ready=1 and a channel is valid in the same cycle, the current word leaves and the new word loads on the same edge.
- Wrap-around: when last_grant=NUM_CH-1, the search starts at channel 0.
- Reset mid-operation: any word in the output register is discarded; no partial state survives.
- Input data need not be stable while in_valid=0. Once in_valid=1, the source must hold data until it sees in_ready.

Optional Feature:
- Macro: STREAM_MUX_LOCK_EN.
- When defined, the in_last and out_last ports exist and bursts are atomic:
  - A transfer with in_last[i]=0 sets lock=1 and pins the grant to channel i.
  - While locked, other channels get in_ready=0 even if channel i is idle.
  - A transfer with in_last[i]=1 clears lock, and round-robin resumes from i+1.
  - out_last is registered alongside out_data.
- When undefined, the ports are absent, there is no lock register, and every word is arbitrated independently.

Test Plan:
- Reset, then raise in_valid=4'b1111 with data ch0..3 = 8'h10,8'h21,8'h32,8'h43 and out_ready=1 held → from cycle 1, out_data sequence is 10,21,32,43,10 with out_ch 0,1,2,3,0 and out_valid continuously 1.
- Only ch2 valid with 8'hA5, out_ready=0 → one word is captured: out_data=A5, out_valid=1, in_ready=0 thereafter. Hold 5 cycles with out_data unchanged. Raise out_ready → the next cycle loads the next ch2 word.
- last_grant=3, ch0 and ch3 both valid → ch0 wins (wrap-around). Next cycle, with both still valid → ch3 wins.
- No inputs valid with out_ready=1 → out_valid drops to 0 one cycle after the last transfer, and out_data holds its last value.
- Assert rst_n=0 asynchronously mid-stream, between clock edges → out_valid=0 immediately. After release, the first grant goes to ch0 when all channels are valid.
- With STREAM_MUX_LOCK_EN, ch1 sends a 3-word burst (in_last on word 3) while ch0 and ch2 are valid → out_ch=1,1,1, then 2, then 0. With the macro undefined, the same stimulus yields out_ch=1,2,0,1,….
